// File: rtl/watch_mode_ctrl.sv
// Digital watch controller: time-of-day clock, stopwatch with lap freeze,
// alarm, and a per-digit edit mode for the clock and alarm times. Times are
// held as six packed BCD nibbles {hd, hu, md, mu, sd, su}.
module watch_mode_ctrl #(
    parameter int TICK_DIV   = 1,
    parameter int CRONO_HMAX = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_change,
    output logic [3:0] d_su,
    output logic [3:0] d_sd,
    output logic [3:0] d_mu,
    output logic [3:0] d_md,
    output logic [3:0] d_hu,
    output logic [3:0] d_hd,
    output logic [1:0] mode,
    output logic [2:0] cfg_digit,
    output logic       alarm_en,
    output logic       alarm_ring,
    output logic       crono_run,
    output logic       lap_hold
);
    typedef enum logic [1:0] {
        M_CLOCK   = 2'd0,
        M_CRONO   = 2'd1,
        M_CFG_CLK = 2'd2,
        M_CFG_ALM = 2'd3
    } mode_t;

    localparam int            PW        = 25;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]    CLK_HMAX  = 8'h23;
    localparam logic [7:0]    SW_HMAX   = {4'(CRONO_HMAX / 10), 4'(CRONO_HMAX % 10)};

    // One-second BCD increment; hours wrap to zero after hmax:59:59.
    function automatic logic [23:0] sec_inc(input logic [23:0] t, input logic [7:0] hmax);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (t[23:16] == hmax) begin
                            r[23:16] = 8'h00;
                        end else if (t[19:16] == 4'd9) begin
                            r[19:16] = 4'd0;
                            r[23:20] = t[23:20] + 4'd1;
                        end else begin
                            r[19:16] = t[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Single-digit edit without carry; hours stay within 00..23.
    function automatic logic [23:0] edit_inc(input logic [23:0] t, input logic [2:0] dig);
        logic [23:0] r;
        r = t;
        case (dig)
            3'd0: r[3:0]   = (t[3:0]   == 4'd9) ? 4'd0 : t[3:0]   + 4'd1;
            3'd1: r[7:4]   = (t[7:4]   == 4'd5) ? 4'd0 : t[7:4]   + 4'd1;
            3'd2: r[11:8]  = (t[11:8]  == 4'd9) ? 4'd0 : t[11:8]  + 4'd1;
            3'd3: r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
            3'd4: begin
                if (t[23:20] == 4'd2)
                    r[19:16] = (t[19:16] >= 4'd3) ? 4'd0 : t[19:16] + 4'd1;
                else
                    r[19:16] = (t[19:16] == 4'd9) ? 4'd0 : t[19:16] + 4'd1;
            end
            3'd5: begin
                if (t[23:20] >= 4'd2) begin
                    r[23:20] = 4'd0;
                end else begin
                    r[23:20] = t[23:20] + 4'd1;
                    if ((t[23:20] == 4'd1) && (t[19:16] > 4'd3))
                        r[19:16] = 4'd3;
                end
            end
            default: r = t;
        endcase
        return r;
    endfunction

    mode_t         r_mode;
    logic [2:0]    r_digit;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_prev;
    logic [23:0]   r_clk, r_sw, r_lap, r_alarm;
    logic          r_en, r_ring, r_run, r_hold;

    logic [2:0]    w_btn, w_rise;
    logic          w_tick, w_clk_adv, w_consume, w_cm, w_cs, w_cc;
    logic [23:0]   w_clk_inc, w_sw_next, w_edit_clk, w_edit_alm, w_disp;

    assign w_btn = {btn_change, btn_start, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_click
            assign w_rise[gi] = w_btn[gi] & ~r_prev[gi];
        end
    endgenerate

    // While ringing, any click only silences the alarm; a mode click masks the others.
    assign w_consume  = r_ring & (|w_rise);
    assign w_cm       = w_rise[0] & ~w_consume;
    assign w_cs       = w_rise[1] & ~w_rise[0] & ~w_consume;
    assign w_cc       = w_rise[2] & ~w_rise[0] & ~w_consume;

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_clk_adv  = w_tick && (r_mode != M_CFG_CLK);
    assign w_clk_inc  = sec_inc(r_clk, CLK_HMAX);
    assign w_sw_next  = (r_run && w_tick) ? sec_inc(r_sw, SW_HMAX) : r_sw;
    assign w_edit_clk = edit_inc(r_clk, r_digit);
    assign w_edit_alm = edit_inc(r_alarm, r_digit);

    // Free-running one-second prescaler shared by clock and stopwatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Previous button levels for rising-edge click detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prev <= 3'b000;
        else        r_prev <= w_btn;
    end

    // Mode FSM with all time registers and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= M_CLOCK;
            r_digit <= 3'd0;
            r_clk   <= 24'h0;
            r_sw    <= 24'h0;
            r_lap   <= 24'h0;
            r_alarm <= 24'h0;
            r_en    <= 1'b0;
            r_ring  <= 1'b0;
            r_run   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_sw <= w_sw_next;
            if (w_clk_adv)
                r_clk <= w_clk_inc;
            if (w_consume || !r_en)
                r_ring <= 1'b0;
            else if (w_clk_adv && (w_clk_inc == r_alarm))
                r_ring <= 1'b1;

            if (w_cm) begin
                r_mode  <= mode_t'(r_mode + 2'd1);
                r_digit <= 3'd0;
            end else begin
                case (r_mode)
                    M_CLOCK: begin
                        if (w_cs) r_en <= ~r_en;
                    end
                    M_CRONO: begin
                        if (w_cs) r_run <= ~r_run;
                        if (w_cc) begin
                            if (r_run) begin
                                r_hold <= ~r_hold;
                                if (!r_hold) r_lap <= w_sw_next;
                            end else begin
                                r_sw   <= 24'h0;
                                r_hold <= 1'b0;
                            end
                        end
                    end
                    M_CFG_CLK: begin
                        if (w_cs) r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
                        if (w_cc) r_clk <= w_edit_clk;
                    end
                    default: begin
                        if (w_cs) r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
                        if (w_cc) r_alarm <= w_edit_alm;
                    end
                endcase
            end
        end
    end

    // Display source select by mode.
    always_comb begin
        w_disp = r_clk;
        case (r_mode)
            M_CRONO:   w_disp = r_hold ? r_lap : r_sw;
            M_CFG_ALM: w_disp = r_alarm;
            default:   w_disp = r_clk;
        endcase
    end

    assign {d_hd, d_hu, d_md, d_mu, d_sd, d_su} = w_disp;
    assign mode       = r_mode;
    assign cfg_digit  = r_digit;
    assign alarm_en   = r_en;
    assign alarm_ring = r_ring;
    assign crono_run  = r_run;
    assign lap_hold   = r_hold;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Scoreboard bench for watch_mode_ctrl with TICK_DIV=1 (a tick every cycle).
module tb_watch_mode_ctrl;
    localparam int S_DISP = 0, S_MODE = 1, S_DIG = 2, S_EN = 3, S_RING = 4, S_RUN = 5, S_LAP = 6;
    localparam int B_MODE = 0, B_START = 1, B_CHG = 2;

    logic       clk, reset, btn_mode, btn_start, btn_change;
    logic [3:0] d_su, d_sd, d_mu, d_md, d_hu, d_hd;
    logic [1:0] mode;
    logic [2:0] cfg_digit;
    logic       alarm_en, alarm_ring, crono_run, lap_hold;

    typedef struct {
        string       name;
        int          sel;
        logic [23:0] val;
    } exp_t;
    exp_t q[$];

    int n_pass = 0, n_total = 0, n_extra = 0;
    int m_ticks = 0;   // clock advances since reset (model)
    int m_off = 0;     // offset applied by clock edits (model)
    int m_mode = 0;    // mode the stimulus expects

    watch_mode_ctrl #(.TICK_DIV(1), .CRONO_HMAX(99)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_start(btn_start),
        .btn_change(btn_change), .d_su(d_su), .d_sd(d_sd), .d_mu(d_mu), .d_md(d_md),
        .d_hu(d_hu), .d_hd(d_hd), .mode(mode), .cfg_digit(cfg_digit),
        .alarm_en(alarm_en), .alarm_ring(alarm_ring), .crono_run(crono_run),
        .lap_hold(lap_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end

    // Clock-time model: one second per cycle outside CFG_CLK.
    always @(posedge clk or negedge reset) begin
        if (!reset)           m_ticks <= 0;
        else if (m_mode != 2) m_ticks <= m_ticks + 1;
    end

    function automatic int cur_secs();
        return (m_ticks + m_off) % 86400;
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, ss;
        h = s / 3600; m = (s / 60) % 60; ss = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic set_secs(input int s);
        m_off = ((s - m_ticks) % 86400 + 86400) % 86400;
    endtask

    task automatic set_hours(input int h);
        set_secs(cur_secs() % 3600 + h * 3600);
    endtask

    task automatic chk(input string n, input int sel, input logic [23:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_MODE:  btn_mode   = v;
            B_START: btn_start  = v;
            default: btn_change = v;
        endcase
    endtask

    task automatic press(input int b);
        @(posedge clk); #1;
        set_btn(b, 1'b1);
        @(posedge clk); #1;
        set_btn(b, 1'b0);
        if (b == B_MODE) m_mode = (m_mode + 1) % 4;
    endtask

    task automatic press_n(input int b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic do_reset();
        btn_mode = 1'b0; btn_start = 1'b0; btn_change = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_off = 0; m_mode = 0;
        chk("rst_disp", S_DISP, 24'h000000);
        chk("rst_mode", S_MODE, 24'd0);
        chk("rst_digit", S_DIG, 24'd0);
        chk("rst_alarm_en", S_EN, 24'd0);
        chk("rst_ring", S_RING, 24'd0);
        chk("rst_run", S_RUN, 24'd0);
        chk("rst_lap", S_LAP, 24'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [23:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_DISP:  act = {d_hd, d_hu, d_md, d_mu, d_sd, d_su};
                S_MODE:  act = {22'd0, mode};
                S_DIG:   act = {21'd0, cfg_digit};
                S_EN:    act = {23'd0, alarm_en};
                S_RING:  act = {23'd0, alarm_ring};
                S_RUN:   act = {23'd0, crono_run};
                default: act = {23'd0, lap_hold};
            endcase
            n_total++;
            if (act === e.val) begin
                n_pass++;
                $display("check %s ok: %h", e.name, act);
            end else begin
                $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
        end
    end

    int s, su, sd;
    logic [3:0] hu_seq [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

    initial begin
        reset = 1'b0;
        btn_mode = 1'b0; btn_start = 1'b0; btn_change = 1'b0;

        // Clock run from reset release through the midnight wrap.
        do_reset();
        for (int k = 1; k <= 86400; k++) begin
            @(posedge clk);
            case (k)
                1:     begin #1 chk("run_00:00:01", S_DISP, 24'h000001); end
                59:    begin #1 chk("run_00:00:59", S_DISP, 24'h000059); end
                60:    begin #1 chk("run_00:01:00", S_DISP, 24'h000100); end
                3600:  begin #1 chk("run_01:00:00", S_DISP, 24'h010000); end
                86399: begin #1 chk("run_23:59:59", S_DISP, 24'h235959); end
                86400: begin #1 chk("run_wrap", S_DISP, 24'h000000); end
                default: ;
            endcase
        end

        // Stopwatch, lap freeze and release.
        do_reset();
        press(B_MODE);
        chk("crono_mode", S_MODE, 24'd1);
        press(B_START);
        chk("sw_run", S_RUN, 24'd1);
        chk("sw_start", S_DISP, 24'h000000);
        repeat (4) @(posedge clk);
        #1 chk("sw_4", S_DISP, 24'h000004);
        btn_change = 1'b1;
        @(posedge clk); #1 btn_change = 1'b0;
        chk("lap_on", S_LAP, 24'd1);
        chk("lap_5", S_DISP, 24'h000005);
        @(posedge clk); #1 chk("lap_hold_a", S_DISP, 24'h000005);
        @(posedge clk); #1 btn_change = 1'b1;
        chk("lap_hold_b", S_DISP, 24'h000005);
        @(posedge clk); #1 btn_change = 1'b0;
        chk("lap_off", S_LAP, 24'd0);
        chk("lap_live_8", S_DISP, 24'h000008);

        // Stop, then clear.
        btn_start = 1'b1;
        @(posedge clk); #1 btn_start = 1'b0;
        chk("sw_stop", S_RUN, 24'd0);
        chk("sw_stop_9", S_DISP, 24'h000009);
        @(posedge clk); #1 chk("sw_frozen_9", S_DISP, 24'h000009);
        btn_change = 1'b1;
        @(posedge clk); #1 btn_change = 1'b0;
        chk("sw_clear", S_DISP, 24'h000000);
        chk("sw_clear_lap", S_LAP, 24'd0);

        // Mode click masks a simultaneous start click.
        @(posedge clk); #1 btn_mode = 1'b1; btn_start = 1'b1;
        @(posedge clk); #1 btn_mode = 1'b0; btn_start = 1'b0;
        m_mode = 2;
        chk("prec_mode", S_MODE, 24'd2);
        chk("prec_run", S_RUN, 24'd0);
        chk("prec_digit", S_DIG, 24'd0);
        chk("cfgclk_disp", S_DISP, to_bcd(cur_secs()));

        // Hour edits with clamp and the 3->0 hu limit at hd=2.
        press_n(B_START, 4);
        chk("digit_4", S_DIG, 24'd4);
        press_n(B_CHG, 7);
        set_hours(7);
        chk("hu_7", S_DISP, to_bcd(cur_secs()));
        press(B_START);
        press(B_CHG);
        set_hours(17);
        chk("hd_1", S_DISP, to_bcd(cur_secs()));
        press(B_CHG);
        set_hours(23);
        chk("hd_2_clamp", S_DISP, to_bcd(cur_secs()));
        press(B_START);
        chk("digit_wrap", S_DIG, 24'd0);
        press_n(B_START, 4);
        for (int i = 0; i < 10; i++) begin
            press(B_CHG);
            set_hours(20 + int'(hu_seq[i]));
            chk($sformatf("hu_step_%0d", i), S_DISP, to_bcd(cur_secs()));
        end

        // Alarm at 00:00:03 reached by a tick; edits alone never ring.
        do_reset();
        press(B_START);
        chk("alarm_en_on", S_EN, 24'd1);
        press_n(B_MODE, 3);
        chk("cfgalm_mode", S_MODE, 24'd3);
        press_n(B_CHG, 3);
        chk("alarm_set", S_DISP, 24'h000003);
        press_n(B_MODE, 3);
        s = cur_secs(); su = s % 10; sd = (s % 60) / 10;
        press_n(B_CHG, (13 - su) % 10);
        press(B_START);
        press_n(B_CHG, (6 - sd) % 6);
        set_secs(s - (s % 60) + 3);
        chk("edit_match_disp", S_DISP, to_bcd(cur_secs()));
        repeat (2) @(posedge clk);
        #1 chk("edit_no_ring", S_RING, 24'd0);
        press_n(B_START, 5);
        chk("digit_back_0", S_DIG, 24'd0);
        press_n(B_CHG, 7);
        set_secs(s - (s % 60));
        chk("clock_zero", S_DISP, to_bcd(cur_secs()));
        press(B_MODE);
        chk("ring_t0", S_RING, 24'd0);
        @(posedge clk); #1 chk("ring_t1", S_RING, 24'd0);
        @(posedge clk); #1 chk("ring_t2", S_RING, 24'd0);
        repeat (3) @(posedge clk);
        #1 chk("ring_set", S_RING, 24'd1);
        press(B_START);
        chk("ring_clear", S_RING, 24'd0);
        chk("ring_en_kept", S_EN, 24'd1);
        chk("ring_click_consumed", S_DIG, 24'd0);
        press(B_START);
        chk("click_after_clear", S_DIG, 24'd1);

        // Reset in the middle of a stopwatch run.
        press_n(B_MODE, 2);
        press(B_START);
        chk("mid_run", S_RUN, 24'd1);
        do_reset();
        repeat (2) @(posedge clk);
        #1 chk("post_reset_clock", S_DISP, 24'h000002);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_extra++;
            $display("FAIL queue_drain: %0d pending, need 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total + n_extra);
        $finish;
    end
endmodule
